// File: rtl/imem_pkg.sv
// Shared constants and loader state type for the instruction memory and its loader.
package imem_pkg;

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned WORD_W = 16;
    localparam int unsigned CNT_W  = 9;
    localparam int unsigned BYTE_W = WORD_W / 2;

    typedef enum logic [2:0] {
        IDLE,
        GET_LO,
        GET_HI,
        WRITE,
        DONE
    } loader_state_t;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
interface imem_loader_if;
    import imem_pkg::*;

    logic              in_valid;
    logic [BYTE_W-1:0] in_data;
    logic              in_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [WORD_W-1:0] wr_data;

    // Loader side: consumes the stream, drives the write port.
    modport slave (
        input  in_valid, in_data,
        output in_ready, wr_en, wr_addr, wr_data
    );

    // Host side: produces the stream, observes the write port.
    modport master (
        output in_valid, in_data,
        input  in_ready, wr_en, wr_addr, wr_data
    );

endinterface

// File: rtl/imem_loader_byte_pack.sv
// Collects low then high stream byte; the packed word only changes on the high byte.
module byte_pack
    import imem_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              lo_we_i,
    input  logic              hi_we_i,
    input  logic [BYTE_W-1:0] data_i,
    output logic [WORD_W-1:0] word_o
);

    logic [BYTE_W-1:0] lo_q;
    logic [WORD_W-1:0] word_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lo_q   <= '0;
            word_q <= '0;
        end else begin
            if (lo_we_i) lo_q <= data_i;
            if (hi_we_i) word_q <= {data_i, lo_q};
        end
    end

    assign word_o = word_q;

endmodule

// File: rtl/imem_loader.sv
// Streams bytes into the instruction memory as 16-bit words, holding the core
// until the load completes and keeping a running checksum of written words.
module imem_loader
    import imem_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  word_count,
    imem_loader_if.slave      bus,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic [WORD_W-1:0] checksum
);

    loader_state_t     state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  rem_q, rem_d;
    logic [WORD_W-1:0] cks_q, cks_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic              in_ready_q, in_ready_d;
    logic              wr_en_q, wr_en_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              lo_we, hi_we, xfer;
    logic [WORD_W-1:0] word;

    byte_pack u_pack (
        .clk     (clk),
        .rst_n   (rst_n),
        .lo_we_i (lo_we),
        .hi_we_i (hi_we),
        .data_i  (bus.in_data),
        .word_o  (word)
    );

    assign xfer = bus.in_valid && in_ready_q;

    // Next state, counters and checksum; outputs are decoded from the next state
    // so that every output comes straight from a flop.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        rem_d     = rem_q;
        cks_d     = cks_q;
        lo_we     = 1'b0;
        hi_we     = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    addr_d  = base_addr;
                    rem_d   = word_count;
                    cks_d   = '0;
                    state_d = (word_count != '0) ? GET_LO : DONE;
                end
            end
            GET_LO: begin
                if (xfer) begin
                    lo_we   = 1'b1;
                    state_d = GET_HI;
                end
            end
            GET_HI: begin
                if (xfer) begin
                    hi_we   = 1'b1;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                cks_d   = WORD_W'(cks_q + word);
                addr_d  = ADDR_W'(addr_q + 1'b1);
                rem_d   = CNT_W'(rem_q - 1'b1);
                state_d = (rem_q == CNT_W'(1)) ? DONE : GET_LO;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        in_ready_d = (state_d == GET_LO) || (state_d == GET_HI);
        wr_en_d    = (state_d == WRITE);
        busy_d     = (state_d != IDLE);
        done_d     = (state_d == DONE);
        wr_addr_d  = (state_d == WRITE) ? addr_d : wr_addr_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            rem_q      <= '0;
            cks_q      <= '0;
            wr_addr_q  <= '0;
            in_ready_q <= 1'b0;
            wr_en_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            rem_q      <= rem_d;
            cks_q      <= cks_d;
            wr_addr_q  <= wr_addr_d;
            in_ready_q <= in_ready_d;
            wr_en_q    <= wr_en_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign bus.in_ready = in_ready_q;
    assign bus.wr_en    = wr_en_q;
    assign bus.wr_addr  = wr_addr_q;
    assign bus.wr_data  = word;
    assign busy         = busy_q;
    assign cpu_hold     = busy_q;
    assign done         = done_q;
    assign checksum     = cks_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes are queued as words are sent
// and matched against the write port as it strobes.
module tb_imem_loader;
    import imem_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic [CNT_W-1:0]  word_count = '0;
    logic              cpu_hold, busy, done;
    logic [WORD_W-1:0] checksum;

    imem_loader_if bus ();

    imem_loader dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .base_addr  (base_addr),
        .word_count (word_count),
        .bus        (bus.slave),
        .cpu_hold   (cpu_hold),
        .busy       (busy),
        .done       (done),
        .checksum   (checksum)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ADDR_W-1:0] a;
        logic [WORD_W-1:0] d;
    } exp_t;

    exp_t              sb[$];
    int                total = 0;
    int                bad = 0;
    int                cyc = 0;
    int                last_wr_cyc = -10;
    logic [ADDR_W-1:0] exp_addr = '0;
    logic [WORD_W-1:0] exp_cks = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Every write strobe must match the oldest queued word.
    always @(negedge clk) begin
        if (bus.wr_en === 1'b1) begin
            exp_t e;
            last_wr_cyc = cyc;
            if (sb.size() == 0) begin
                check("wr_unexpected", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("wr_addr", 32'(bus.wr_addr), 32'(e.a));
                check("wr_data", 32'(bus.wr_data), 32'(e.d));
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        for (int i = 0; i < 20 && bus.in_ready !== 1'b1; i++) @(negedge clk);
        if (bus.in_ready !== 1'b1) check("ready_timeout", 32'd0, 32'd1);
        @(negedge clk);
    endtask

    task automatic send_word(input logic [15:0] w, input int gap);
        send_byte(w[7:0]);
        for (int i = 0; i < gap; i++) begin
            bus.in_valid = 1'b0;
            bus.in_data  = 8'($urandom);
            check("gap_ready", 32'(bus.in_ready), 32'd1);
            check("gap_wr_en", 32'(bus.wr_en), 32'd0);
            @(negedge clk);
        end
        sb.push_back('{a: exp_addr, d: w});
        exp_cks  = WORD_W'(exp_cks + w);
        exp_addr = ADDR_W'(exp_addr + 1'b1);
        send_byte(w[15:8]);
    endtask

    task automatic do_start(input logic [ADDR_W-1:0] b, input logic [CNT_W-1:0] n);
        base_addr  = b;
        word_count = n;
        start      = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        exp_addr = b;
        exp_cks  = '0;
        check("start_busy", 32'(busy), 32'd1);
    endtask

    task automatic wait_done(input string tag, input bit chk_lat);
        bus.in_valid = 1'b0;
        for (int i = 0; i < 50 && done !== 1'b1; i++) @(negedge clk);
        check({tag, "_done"}, 32'(done), 32'd1);
        if (chk_lat) check({tag, "_done_lat"}, 32'(cyc - last_wr_cyc), 32'd1);
        check({tag, "_cks"}, 32'(checksum), 32'(exp_cks));
        check({tag, "_hold"}, 32'(cpu_hold), 32'd1);
        check({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
        @(negedge clk);
        check({tag, "_done_drop"}, 32'(done), 32'd0);
        check({tag, "_busy_drop"}, 32'(busy), 32'd0);
        check({tag, "_hold_drop"}, 32'(cpu_hold), 32'd0);
        check({tag, "_cks_hold"}, 32'(checksum), 32'(exp_cks));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd0);
        check({tag, "_wr_en"}, 32'(bus.wr_en), 32'd0);
        check({tag, "_wr_addr"}, 32'(bus.wr_addr), 32'd0);
        check({tag, "_wr_data"}, 32'(bus.wr_data), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_hold"}, 32'(cpu_hold), 32'd0);
        check({tag, "_cks"}, 32'(checksum), 32'd0);
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        repeat (2) @(negedge clk);
        check_reset_outputs("rst");
        rst_n = 1'b1;
        @(negedge clk);

        // Basic two-word load with continuous valid.
        do_start(8'h00, 9'd2);
        send_word(16'h1234, 0);
        send_word(16'h5678, 0);
        wait_done("t1", 1'b1);
        check("t1_cks_const", 32'(checksum), 32'h68AC);

        // Zero-length load: straight to DONE, no writes.
        base_addr  = 8'h05;
        word_count = 9'd0;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("t2_busy", 32'(busy), 32'd1);
        check("t2_done", 32'(done), 32'd1);
        check("t2_wr_en", 32'(bus.wr_en), 32'd0);
        @(negedge clk);
        check("t2_busy_drop", 32'(busy), 32'd0);
        check("t2_done_drop", 32'(done), 32'd0);
        check("t2_cks", 32'(checksum), 32'd0);

        // Address wrap over the top of memory.
        do_start(8'hFE, 9'd3);
        send_word(16'h0001, 0);
        send_word(16'h0002, 0);
        send_word(16'h0003, 0);
        wait_done("t3", 1'b1);
        check("t3_cks_const", 32'(checksum), 32'h0006);

        // Stall between low and high byte.
        do_start(8'h10, 9'd2);
        send_word(16'hCAFE, 5);
        send_word(16'h0102, 0);
        wait_done("t4", 1'b1);

        // Start mid-load must be ignored.
        do_start(8'h80, 9'd3);
        send_word(16'h1111, 0);
        bus.in_valid = 1'b0;
        base_addr    = 8'h40;
        word_count   = 9'd7;
        start        = 1'b1;
        @(negedge clk);
        start = 1'b0;
        send_word(16'h2222, 0);
        send_word(16'h3333, 0);
        wait_done("t5", 1'b1);

        // Reset while waiting for the high byte of word 2.
        do_start(8'h10, 9'd3);
        send_word(16'hAAAA, 0);
        send_byte(8'h55);
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("t6_rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("t6_idle_busy", 32'(busy), 32'd0);
        do_start(8'h20, 9'd1);
        send_word(16'hBEEF, 0);
        wait_done("t6", 1'b1);
        check("t6_cks_const", 32'(checksum), 32'hBEEF);
        check("sb_final", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
